// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: paces MCP3002 conversions on a fixed sample tick and emits one frame of samples.
// A tick that lands while a conversion is still running is dropped and latched in overrun.
module adc_sample_scheduler #(
    parameter int CLK_FREQ          = 48_000_000,
    parameter int MCP3002_CLK_FREQ  = 800_000,
    parameter int ADC_SAMPLING_FREQ = 48_000,
    parameter int FRAME_LEN         = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       adc_cs,
    output logic       adc_clk,
    output logic       adc_din,
    input  logic       adc_dout,
    output logic       sample_valid,
    output logic [9:0] sample_data,
    output logic [9:0] sample_index,
    output logic       frame_done,
    output logic       overrun
);
    localparam int HALF         = CLK_FREQ / (2 * MCP3002_CLK_FREQ);
    localparam int SAMPLE_CYCLE = CLK_FREQ / ADC_SAMPLING_FREQ;
    localparam int TW           = $clog2(SAMPLE_CYCLE + 1);
    localparam int PW           = $clog2(HALF + 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, SCLK_LOW, SCLK_HIGH, EMIT} state_t;

    state_t        r_state, w_next;
    logic [TW-1:0] r_tick;
    logic [PW-1:0] r_ph;
    logic [3:0]    r_bit;
    logic [9:0]    r_cnt, r_shift, r_data, r_index;
    logic          r_busy, r_valid, r_done, r_ovr;
    logic          w_go, w_abort, w_tick, w_ph_end, w_spi, w_emit, w_last;

    always_comb begin
        w_abort  = abort && r_busy;
        w_go     = r_state == IDLE && start && !abort && !r_busy;
        w_tick   = r_busy && r_tick == TW'(SAMPLE_CYCLE - 1);
        w_ph_end = r_ph == PW'(HALF - 1);
        w_spi    = r_state == SCLK_LOW || r_state == SCLK_HIGH;
        w_emit   = r_state == EMIT && !w_abort;
        w_last   = r_cnt == 10'(FRAME_LEN - 1);
    end

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_go ? SCLK_LOW : IDLE;
            WAIT_TICK: w_next = w_tick ? SCLK_LOW : WAIT_TICK;
            SCLK_LOW:  w_next = w_ph_end ? SCLK_HIGH : SCLK_LOW;
            SCLK_HIGH: w_next = !w_ph_end ? SCLK_HIGH : (r_bit == 4'd15) ? EMIT : SCLK_LOW;
            EMIT:      w_next = w_last ? IDLE : WAIT_TICK;
            default:   w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick  <= '0;
            r_ph    <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_tick  <= (w_go || w_tick) ? '0 : r_busy ? r_tick + TW'(1) : r_tick;
            r_busy  <= w_go || (r_busy && !w_abort && !r_done);
            r_ph    <= (w_spi && !w_ph_end) ? r_ph + PW'(1) : '0;
            r_bit   <= !w_spi ? 4'd0 : (r_state == SCLK_HIGH && w_ph_end) ? r_bit + 4'd1 : r_bit;
            // data bits arrive on SPI clocks 6..15, captured on the first high cycle
            if (r_state == SCLK_HIGH && r_ph == '0 && r_bit >= 4'd5 && r_bit <= 4'd14)
                r_shift <= {r_shift[8:0], adc_dout};
            r_valid <= w_emit;
            r_done  <= w_emit && w_last;
            if (w_emit) begin
                r_data  <= r_shift;
                r_index <= r_cnt;
            end
            r_cnt   <= w_go ? '0 : w_emit ? r_cnt + 10'd1 : r_cnt;
            r_ovr   <= !w_go && (r_ovr || (w_tick && (w_spi || r_state == EMIT)));
        end
    end

    always_comb begin
        adc_cs       = !w_spi;
        adc_clk      = r_state == SCLK_HIGH;
        adc_din      = w_spi && (r_bit == 4'd0 || r_bit == 4'd1 || r_bit == 4'd3);
        busy         = r_busy;
        sample_valid = r_valid;
        sample_data  = r_data;
        sample_index = r_index;
        frame_done   = r_done;
        overrun      = r_ovr;
    end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: two scheduler instances (no-collision and overrun rates) against a schedule-level model.
module tb_adc_sample_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] st = '0, ab = '0, dout = '0;
    logic [1:0] busy, cs, sclk, din, vld, done, ovr;
    logic [9:0] data [2];
    logic [9:0] idx [2];
    logic [9:0] aval [2] = '{10'h2A4, 10'h000};
    int         checks = 0, errors = 0, cyc = 0;
    int         rc [2] = '{0, 0};
    logic       pcs [2] = '{1'b1, 1'b1};
    logic       pclk [2] = '{1'b0, 1'b0};
    int         t0 [2] = '{0, 0};
    int         scy [2] = '{80, 50};
    int         fln [2] = '{1024, 8};
    bit         act [2] = '{1'b0, 1'b0};
    bit         eov [2] = '{1'b0, 1'b0};
    bit         bp [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    adc_sample_scheduler #(.CLK_FREQ(48_000_000), .MCP3002_CLK_FREQ(12_000_000),
                           .ADC_SAMPLING_FREQ(600_000), .FRAME_LEN(1024)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .busy(busy[0]),
        .adc_cs(cs[0]), .adc_clk(sclk[0]), .adc_din(din[0]), .adc_dout(dout[0]),
        .sample_valid(vld[0]), .sample_data(data[0]), .sample_index(idx[0]),
        .frame_done(done[0]), .overrun(ovr[0]));

    adc_sample_scheduler #(.CLK_FREQ(48_000_000), .MCP3002_CLK_FREQ(12_000_000),
                           .ADC_SAMPLING_FREQ(960_000), .FRAME_LEN(8)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .busy(busy[1]),
        .adc_cs(cs[1]), .adc_clk(sclk[1]), .adc_din(din[1]), .adc_dout(dout[1]),
        .sample_valid(vld[1]), .sample_data(data[1]), .sample_index(idx[1]),
        .frame_done(done[1]), .overrun(ovr[1]));

    // MCP3002 model: a new value per conversion, data bit for SPI clock s is value[15-s]
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int s;
            if (cs[i]) rc[i] = 0;
            else begin
                if (pcs[i]) aval[i] = (i == 0) ? aval[i] + 10'd1 : 10'($urandom);
                if (sclk[i] && !pclk[i]) rc[i]++;
            end
            s = sclk[i] ? rc[i] : rc[i] + 1;
            dout[i] = (!cs[i] && s >= 6 && s <= 15) ? aval[i][15-s] : 1'b0;
            pcs[i] = cs[i];
            pclk[i] = sclk[i];
        end
    end

    // schedule model: conversion k of a frame starts k*step cycles after the first adc_cs fall
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int o, k, p, oe, stp;
            logic [6:0] e, a;
            stp = scy[i] * ((65 + scy[i]) / scy[i]);
            if (rst) begin
                act[i] = 1'b0;
                eov[i] = 1'b0;
            end else if (ab[i] && bp[i]) act[i] = 1'b0;
            else if (st[i] && !ab[i] && !bp[i]) begin
                act[i] = 1'b1;
                t0[i] = cyc;
                eov[i] = 1'b0;
            end
            o = cyc - t0[i];
            oe = (fln[i] - 1) * stp + 65;
            if (act[i] && o > oe) act[i] = 1'b0;
            k = o / stp;
            p = o % stp;
            if (act[i] && stp > scy[i] && o >= scy[i]) eov[i] = 1'b1;
            e = {!(act[i] && p < 64), act[i] && p < 64 && (p / 2) % 2 == 1,
                 act[i] && p < 64 && (p / 4 == 0 || p / 4 == 1 || p / 4 == 3),
                 act[i], act[i] && p == 65, act[i] && p == 65 && k == fln[i] - 1, eov[i]};
            a = {cs[i], sclk[i], din[i], busy[i], vld[i], done[i], ovr[i]};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctl%0d cyc %0d cs/clk/din/busy/vld/done/ovr got %b want %b", i, cyc, a, e);
            end
            if (e[2]) begin
                checks++;
                if (data[i] !== aval[i] || idx[i] !== 10'(k)) begin
                    errors++;
                    $display("FAIL sample%0d cyc %0d got data %h idx %0d want data %h idx %0d",
                             i, cyc, data[i], idx[i], aval[i], k);
                end
            end
            bp[i] = e[3];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic wait_fall(input int i, output int n);
        logic p, f;
        n = 0;
        p = cs[i];
        f = 1'b0;
        while (!f && n < 300) begin
            @(negedge clk);
            n++;
            f = p && !cs[i];
            p = cs[i];
        end
        if (!f) chk("cs_fall_timeout", 0, 1);
    endtask

    task automatic run_a();
        int n, r, nv, nd, first, last, dn;
        logic [3:0] dv;
        logic pc;
        repeat (2) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        chk("a_cs_after_start", cs[0], 0);
        n = 0; r = 0; pc = 1'b0; dv = '0;
        while (!vld[0] && n < 200) begin
            @(negedge clk);
            n++;
            if (sclk[0] && !pc && r < 4) begin
                dv[3-r] = din[0];
                r++;
            end
            pc = sclk[0];
        end
        chk("a_latency", n, 65);
        chk("a_din_1_4", dv, 4'b1101);
        chk("a_data0", data[0], 10'h2A5);
        chk("a_index0", idx[0], 0);
        for (int j = 0; j < 5; j++) wait_fall(0, n);
        chk("a_spacing", n, 80);
        repeat (28 + $urandom_range(0, 3)) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("a_abort_cs", cs[0], 1);
        chk("a_abort_busy", busy[0], 0);
        nv = 0;
        repeat (100) begin
            @(negedge clk);
            nv += int'(vld[0]) + int'(done[0]);
        end
        chk("a_abort_no_valid", nv, 0);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0; nv = 0; nd = 0; first = -1; last = -1; dn = -1;
        do begin
            @(negedge clk);
            n++;
            st[0] = busy[0] && $urandom_range(0, 499) == 0;
            if (vld[0]) begin
                if (first < 0) first = int'(idx[0]);
                last = int'(idx[0]);
                nv++;
            end
            if (done[0]) begin
                nd++;
                dn = int'(idx[0]);
            end
        end while (busy[0] && n < 90000);
        st[0] = 1'b0;
        chk("a_frame_count", nv, 1024);
        chk("a_first_index", first, 0);
        chk("a_last_index", last, 1023);
        chk("a_done_count", nd, 1);
        chk("a_done_index", dn, 1023);
    endtask

    task automatic run_b();
        int n;
        for (int f = 0; f < 3; f++) begin
            repeat ($urandom_range(2, 30)) @(negedge clk);
            st[1] = 1'b1;
            @(negedge clk);
            st[1] = 1'b0;
            chk("b_ovr_cleared", ovr[1], 0);
            n = 0;
            while (!ovr[1] && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("b_ovr_first_tick", n, 50);
            wait_fall(1, n);
            wait_fall(1, n);
            chk("b_spacing", n, 100);
            n = 0;
            while (busy[1] && n < 2000) begin
                @(negedge clk);
                n++;
                st[1] = busy[1] && $urandom_range(0, 40) == 0;
            end
            st[1] = 1'b0;
            chk("b_frame_end", busy[1], 0);
            chk("b_ovr_sticky", ovr[1], 1);
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                chk("reset_state", {cs[i], sclk[i], busy[i], ovr[i]}, 4'b1000);
        end
        rst = 1'b0;
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
